interact_arbiter: RTL and testbench

- Shares the single kitchen-grid tile RAM port between N_PLAYERS players issuing interact (pick-up/place) requests.
- Round-robin arbitration; latches the winner's position and facing; computes the facing tile (LEFT x-1, RIGHT x+1, UP y-1, DOWN y+1).
- Read-modify-writes that tile's object code and returns a status plus the player's new held object.
- Sits between the per-player input/movement logic and the grid tile memory.

---
 rtl/interact_arbiter.sv | 263 ++++++++++++++++++++++++++
 tb/tb_interact_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interact_arbiter.sv
// interact_arbiter: shares the single tile RAM port between players issuing
// interact (pick-up / place) requests. A round-robin grant picks one player,
// the tile in front of it is read, and the tile and the held object are
// swapped when the move is legal. A status and the new held object are
// returned together with a one-cycle ack.
module interact_arbiter #(
   parameter int N_PLAYERS = 2,
   parameter int GRID_W    = 16,
   parameter int GRID_H    = 8,
   parameter int RD_LAT    = 1
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [N_PLAYERS-1:0]   req_in,
   output logic [N_PLAYERS-1:0]   ack_out,
   input  logic [4*N_PLAYERS-1:0] grid_x_in,
   input  logic [3*N_PLAYERS-1:0] grid_y_in,
   input  logic [2*N_PLAYERS-1:0] dir_in,
   input  logic [4*N_PLAYERS-1:0] held_in,
   output logic [6:0]             mem_addr_out,
   output logic                   mem_rd_out,
   input  logic [3:0]             mem_rdata_in,
   output logic                   mem_we_out,
   output logic [3:0]             mem_wdata_out,
   output logic                   resp_valid_out,
   output logic [1:0]             resp_player_out,
   output logic [1:0]             resp_status_out,
   output logic [3:0]             resp_held_out
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DECIDE,
      ST_WRITE,
      ST_RESP
   } state_t;

   localparam logic [1:0] DIR_LEFT  = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_UP    = 2'd2;

   localparam logic [1:0] STAT_PICKED  = 2'd0;
   localparam logic [1:0] STAT_PLACED  = 2'd1;
   localparam logic [1:0] STAT_BLOCKED = 2'd2;
   localparam logic [1:0] STAT_OOB     = 2'd3;

   // Grid limits in the signed space used for the front-tile arithmetic.
   localparam logic signed [5:0] X_MAX = 6'(GRID_W - 1);
   localparam logic signed [5:0] Y_MAX = 6'(GRID_H - 1);

   // WAIT lasts RD_LAT-1 cycles; the counter runs down to zero.
   localparam logic [1:0] WAIT_INIT = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

   state_t     state_reg;
   logic [1:0] last_grant_reg;
   logic [1:0] player_reg;
   logic [3:0] held_reg;
   logic       oob_reg;
   logic [1:0] wait_cnt_reg;
   logic [1:0] pend_status_reg;
   logic [3:0] pend_held_reg;

   // Front tile of every player, computed in parallel so the winner's result
   // can be latched at the grant edge together with its other inputs.
   logic [7*N_PLAYERS-1:0] front_addr;
   logic [N_PLAYERS-1:0]   front_oob;

   genvar gi;
   generate
      for (gi = 0; gi < N_PLAYERS; gi++) begin : g_front
         logic [1:0]        dir;
         logic signed [5:0] dx;
         logic signed [5:0] dy;
         logic signed [5:0] fx;
         logic signed [5:0] fy;

         assign dir = dir_in[2*gi +: 2];

         // Unit step toward the facing direction.
         always_comb begin
            dx = '0;
            dy = '0;
            case (dir)
               DIR_LEFT:  dx = -6'sd1;
               DIR_RIGHT: dx = 6'sd1;
               DIR_UP:    dy = -6'sd1;
               default:   dy = 6'sd1;
            endcase
         end

         assign fx = signed'({2'b00, grid_x_in[4*gi +: 4]}) + dx;
         assign fy = signed'({3'b000, grid_y_in[3*gi +: 3]}) + dy;

         assign front_oob[gi] = (fx < 6'sd0) || (fx > X_MAX) ||
                                (fy < 6'sd0) || (fy > Y_MAX);
         assign front_addr[7*gi +: 7] = {fy[2:0], fx[3:0]};
      end
   endgenerate

   // Requests rotated so bit 0 is the player right after the last grant.
   logic [N_PLAYERS-1:0] req_rot;
   assign req_rot = N_PLAYERS'({req_in, req_in} >> ({1'b0, last_grant_reg} + 3'd1));

   logic       grant_valid;
   logic [1:0] grant_idx;

   // Round-robin pick: lowest rotated position wins (scanned high to low).
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int j = N_PLAYERS - 1; j >= 0; j--) begin
         if (req_rot[j]) begin
            grant_valid = 1'b1;
            grant_idx   = 2'((int'(last_grant_reg) + 1 + j) % N_PLAYERS);
         end
      end
   end

   logic [6:0] win_addr;
   logic       win_oob;
   logic [3:0] win_held;

   // Select the granted player's front tile and held object.
   always_comb begin
      win_addr = '0;
      win_oob  = 1'b0;
      win_held = '0;
      for (int p = 0; p < N_PLAYERS; p++) begin
         if (grant_idx == 2'(p)) begin
            win_addr = front_addr[7*p +: 7];
            win_oob  = front_oob[p];
            win_held = held_in[4*p +: 4];
         end
      end
   end

   function automatic logic [N_PLAYERS-1:0] player_onehot(input logic [1:0] idx);
      logic [N_PLAYERS-1:0] v;
      v = '0;
      for (int p = 0; p < N_PLAYERS; p++) begin
         v[p] = (idx == 2'(p));
      end
      return v;
   endfunction

   // Operation sequencer with registered memory and response outputs.
   // Strobes default low every cycle so each is a single-cycle pulse.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_reg       <= ST_IDLE;
         last_grant_reg  <= 2'(N_PLAYERS - 1);
         player_reg      <= '0;
         held_reg        <= '0;
         oob_reg         <= 1'b0;
         wait_cnt_reg    <= '0;
         pend_status_reg <= '0;
         pend_held_reg   <= '0;
         ack_out         <= '0;
         mem_addr_out    <= '0;
         mem_rd_out      <= 1'b0;
         mem_we_out      <= 1'b0;
         mem_wdata_out   <= '0;
         resp_valid_out  <= 1'b0;
         resp_player_out <= '0;
         resp_status_out <= '0;
         resp_held_out   <= '0;
      end else begin
         mem_rd_out      <= 1'b0;
         mem_we_out      <= 1'b0;
         mem_wdata_out   <= '0;
         resp_valid_out  <= 1'b0;
         ack_out         <= '0;
         resp_player_out <= '0;
         resp_status_out <= '0;
         resp_held_out   <= '0;

         case (state_reg)
            ST_IDLE: begin
               if (grant_valid) begin
                  last_grant_reg <= grant_idx;
                  player_reg     <= grant_idx;
                  held_reg       <= win_held;
                  oob_reg        <= win_oob;
                  // The read strobe is raised for the ISSUE cycle only when
                  // the front tile lies inside the grid.
                  if (!win_oob) begin
                     mem_addr_out <= win_addr;
                     mem_rd_out   <= 1'b1;
                  end
                  state_reg <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               if (oob_reg) begin
                  resp_valid_out  <= 1'b1;
                  ack_out         <= player_onehot(player_reg);
                  resp_player_out <= player_reg;
                  resp_status_out <= STAT_OOB;
                  resp_held_out   <= held_reg;
                  state_reg       <= ST_RESP;
               end else if (RD_LAT == 1) begin
                  state_reg <= ST_DECIDE;
               end else begin
                  wait_cnt_reg <= WAIT_INIT;
                  state_reg    <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (wait_cnt_reg == 2'd0) begin
                  state_reg <= ST_DECIDE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - 2'd1;
               end
            end

            ST_DECIDE: begin
               if ((held_reg == 4'd0) && (mem_rdata_in != 4'd0)) begin
                  pend_status_reg <= STAT_PICKED;
                  pend_held_reg   <= mem_rdata_in;
                  mem_we_out      <= 1'b1;
                  mem_wdata_out   <= 4'd0;
                  state_reg       <= ST_WRITE;
               end else if ((held_reg != 4'd0) && (mem_rdata_in == 4'd0)) begin
                  pend_status_reg <= STAT_PLACED;
                  pend_held_reg   <= 4'd0;
                  mem_we_out      <= 1'b1;
                  mem_wdata_out   <= held_reg;
                  state_reg       <= ST_WRITE;
               end else begin
                  resp_valid_out  <= 1'b1;
                  ack_out         <= player_onehot(player_reg);
                  resp_player_out <= player_reg;
                  resp_status_out <= STAT_BLOCKED;
                  resp_held_out   <= held_reg;
                  state_reg       <= ST_RESP;
               end
            end

            ST_WRITE: begin
               resp_valid_out  <= 1'b1;
               ack_out         <= player_onehot(player_reg);
               resp_player_out <= player_reg;
               resp_status_out <= pend_status_reg;
               resp_held_out   <= pend_held_reg;
               state_reg       <= ST_RESP;
            end

            ST_RESP: begin
               state_reg <= ST_IDLE;
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_interact_arbiter.sv
// Directed bench for interact_arbiter: pick-up, place, blocked, out-of-grid,
// contention between two players and reset in the middle of an operation.
module tb_interact_arbiter;

   logic       clk;
   logic       rst;
   logic [1:0] req;
   logic [1:0] ack;
   logic [7:0] gx;
   logic [5:0] gy;
   logic [3:0] dir;
   logic [7:0] held;
   logic [6:0] mem_addr;
   logic       mem_rd;
   logic [3:0] mem_rdata;
   logic       mem_we;
   logic [3:0] mem_wdata;
   logic       resp_valid;
   logic [1:0] resp_player;
   logic [1:0] resp_status;
   logic [3:0] resp_held;

   interact_arbiter #(
      .N_PLAYERS(2), .GRID_W(16), .GRID_H(8), .RD_LAT(1)
   ) dut (
      .clk_in(clk), .rst_in(rst), .req_in(req), .ack_out(ack),
      .grid_x_in(gx), .grid_y_in(gy), .dir_in(dir), .held_in(held),
      .mem_addr_out(mem_addr), .mem_rd_out(mem_rd), .mem_rdata_in(mem_rdata),
      .mem_we_out(mem_we), .mem_wdata_out(mem_wdata),
      .resp_valid_out(resp_valid), .resp_player_out(resp_player),
      .resp_status_out(resp_status), .resp_held_out(resp_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tile RAM model with one cycle of read latency and a preload port.
   logic [3:0] ram [128];
   logic       poke_en;
   logic [6:0] poke_addr;
   logic [3:0] poke_data;

   always @(posedge clk) begin
      if (poke_en) ram[poke_addr] <= poke_data;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= ram[mem_addr];
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Observations of one operation.
   int         obs_lat;
   logic [1:0] obs_player, obs_status, obs_ack, ack_after;
   logic [3:0] obs_held;
   int         rd_cnt, we_cnt, overlap;
   logic [6:0] rd_addr, we_addr;
   logic [3:0] we_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [6:0] a, input logic [3:0] d);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   task automatic set_player(input int p, input logic [3:0] x, input logic [2:0] y,
                             input logic [1:0] d, input logic [3:0] h);
      gx[4*p +: 4]   = x;
      gy[3*p +: 3]   = y;
      dir[2*p +: 2]  = d;
      held[4*p +: 4] = h;
   endtask

   // Raise one request and watch until the response; latency counts edges
   // from the grant edge to the edge that closes the RESP cycle.
   task automatic run_op(input int p);
      bit done;
      int k;
      rd_cnt = 0; we_cnt = 0; overlap = 0; rd_addr = '0; we_addr = '0; we_data = '0;
      obs_lat = -1; obs_player = '0; obs_status = '0; obs_held = '0; obs_ack = '0;
      done = 1'b0;
      req[p] = 1'b1;
      @(posedge clk); #1;
      k = 0;
      while (!done && k < 30) begin
         if (mem_rd) begin rd_cnt++; rd_addr = mem_addr; end
         if (mem_we) begin we_cnt++; we_addr = mem_addr; we_data = mem_wdata; end
         if (mem_rd && mem_we) overlap++;
         if (resp_valid) begin
            obs_lat = k + 1; obs_player = resp_player; obs_status = resp_status;
            obs_held = resp_held; obs_ack = ack; done = 1'b1;
         end else begin
            @(posedge clk); #1;
            k++;
         end
      end
      req[p] = 1'b0;
      @(posedge clk); #1;
      ack_after = ack;
      $display("op p%0d lat=%0d player=%0d status=%0d held=%0h rd=%0d@%0h we=%0d@%0h<-%0h",
               p, obs_lat, obs_player, obs_status, obs_held, rd_cnt, rd_addr, we_cnt, we_addr, we_data);
   endtask

   logic [1:0] order [4];
   logic [1:0] ack_seen [4];
   int n_resp, ack_cycles, strobes;
   bit we_seen;

   initial begin
      rst = 1'b0; req = '0; gx = '0; gy = '0; dir = '0; held = '0;
      poke_en = 1'b0; poke_addr = '0; poke_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {ack, mem_addr, mem_rd, mem_we, mem_wdata, resp_valid,
                              resp_player, resp_status, resp_held}, 32'h0);
      rst = 1'b1;
      poke(7'h24, 4'd5);   // (x=4,y=2)
      poke(7'h44, 4'd0);   // (x=4,y=4)
      poke(7'h47, 4'd6);   // (x=7,y=4)
      poke(7'h7E, 4'd0);   // (x=14,y=7)

      // Pick-up: P0 at (3,2) facing RIGHT, empty hands, tile 5.
      set_player(0, 4'd3, 3'd2, 2'd1, 4'd0);
      run_op(0);
      check("pick_lat", obs_lat, 4);
      check("pick_status", obs_status, 0);
      check("pick_held", obs_held, 5);
      check("pick_player", obs_player, 0);
      check("pick_ack", obs_ack, 2'b01);
      check("pick_ack_1cyc", ack_after, 0);
      check("pick_rd", {rd_cnt[7:0], 1'b0, rd_addr}, {8'd1, 8'h24});
      check("pick_we", {we_cnt[7:0], 1'b0, we_addr, 4'h0, we_data}, {8'd1, 8'h24, 8'h00});
      check("pick_ram", ram[7'h24], 0);

      // Place: P1 at (4,5) facing UP holding 7 onto empty tile (4,4).
      set_player(1, 4'd4, 3'd5, 2'd2, 4'd7);
      run_op(1);
      check("place_lat", obs_lat, 4);
      check("place_status", obs_status, 1);
      check("place_held", obs_held, 0);
      check("place_player", obs_player, 1);
      check("place_ack", obs_ack, 2'b10);
      check("place_we", {we_cnt[7:0], 1'b0, we_addr, 4'h0, we_data}, {8'd1, 8'h44, 8'h07});
      check("place_ram", ram[7'h44], 7);

      // Blocked: P0 at (7,3) facing DOWN holding 3, tile holds 6.
      set_player(0, 4'd7, 3'd3, 2'd3, 4'd3);
      run_op(0);
      check("blk_lat", obs_lat, 3);
      check("blk_status", obs_status, 2);
      check("blk_held", obs_held, 3);
      check("blk_rd", {rd_cnt[7:0], 1'b0, rd_addr}, {8'd1, 8'h47});
      check("blk_we_cnt", we_cnt, 0);
      check("blk_ram", ram[7'h47], 6);

      // Out of grid: (0,0) LEFT, (15,7) RIGHT, (15,7) DOWN.
      set_player(0, 4'd0, 3'd0, 2'd0, 4'd2);
      run_op(0);
      check("oob_left_lat", obs_lat, 2);
      check("oob_left_status", obs_status, 3);
      check("oob_left_held", obs_held, 2);
      check("oob_left_mem", rd_cnt + we_cnt, 0);
      set_player(1, 4'd15, 3'd7, 2'd1, 4'd0);
      run_op(1);
      check("oob_right_lat", obs_lat, 2);
      check("oob_right_status", obs_status, 3);
      check("oob_right_mem", rd_cnt + we_cnt, 0);
      set_player(0, 4'd15, 3'd7, 2'd3, 4'd0);
      run_op(0);
      check("oob_down_lat", obs_lat, 2);
      check("oob_down_status", obs_status, 3);
      check("oob_down_mem", rd_cnt + we_cnt, 0);

      // Edge column facing inward stays in the grid: (15,7) LEFT -> (14,7) empty.
      set_player(1, 4'd15, 3'd7, 2'd0, 4'd0);
      run_op(1);
      check("edge_in_rd", {rd_cnt[7:0], 1'b0, rd_addr}, {8'd1, 8'h7E});
      check("edge_in_status", obs_status, 2);
      check("edge_in_lat", obs_lat, 3);

      // Contention from reset: both request continuously for four operations.
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      set_player(0, 4'd0, 3'd0, 2'd0, 4'd1);
      set_player(1, 4'd15, 3'd7, 2'd3, 4'd2);
      req = 2'b11; n_resp = 0; ack_cycles = 0; overlap = 0;
      for (int c = 0; c < 40 && n_resp < 4; c++) begin
         @(posedge clk); #1;
         if (mem_rd && mem_we) overlap++;
         if (ack != 2'b00) ack_cycles++;
         if (resp_valid) begin
            order[n_resp] = resp_player;
            ack_seen[n_resp] = ack;
            $display("contention resp %0d player=%0d ack=%b status=%0d held=%0h",
                     n_resp, resp_player, ack, resp_status, resp_held);
            n_resp++;
            if (n_resp == 4) req = 2'b00;
         end
      end
      @(posedge clk); #1;
      if (ack != 2'b00) ack_cycles++;
      check("cont_count", n_resp, 4);
      for (int i = 0; i < n_resp; i++) begin
         check($sformatf("cont_order%0d", i), order[i], i % 2);
         check($sformatf("cont_ack%0d", i), ack_seen[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      check("cont_ack_cycles", ack_cycles, 4);
      check("cont_overlap", overlap, 0);

      // Reset during WRITE of a P0 pick-up; pointer must return to P0 first.
      poke(7'h24, 4'd9);
      set_player(0, 4'd3, 3'd2, 2'd1, 4'd0);
      req = 2'b01; we_seen = 1'b0;
      for (int c = 0; c < 20 && !we_seen; c++) begin
         @(posedge clk); #1;
         if (mem_we) we_seen = 1'b1;
      end
      check("rst_reach_write", we_seen, 1);
      rst = 1'b0; req = 2'b00;
      @(posedge clk); #1;
      check("rst_mid_outputs", {ack, mem_addr, mem_rd, mem_we, mem_wdata, resp_valid,
                                resp_player, resp_status, resp_held}, 32'h0);
      rst = 1'b1;
      strobes = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (mem_rd || mem_we || resp_valid || (ack != 2'b00)) strobes++;
      end
      check("rst_quiet", strobes, 0);
      set_player(0, 4'd0, 3'd0, 2'd0, 4'd4);
      set_player(1, 4'd15, 3'd7, 2'd3, 4'd5);
      req = 2'b11; n_resp = 0;
      for (int c = 0; c < 20 && n_resp == 0; c++) begin
         @(posedge clk); #1;
         if (resp_valid) begin
            order[0] = resp_player;
            obs_held = resp_held;
            n_resp = 1;
            req = 2'b00;
         end
      end
      $display("post-reset grant player=%0d held=%0h", order[0], obs_held);
      check("rst_resp_seen", n_resp, 1);
      check("rst_next_grant", order[0], 0);
      check("rst_next_held", obs_held, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
